// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box display: screen defaults, position
// width and the motion controller state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int POS_W        = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MOVE_X,
    MOVE_Y,
    COMMIT
  } boxStateT;

endpackage

// File: rtl/vga_axis_step.sv
// Combinational reflect/clamp for one axis: advances pos by STEP in the
// current direction, clamping to [0, MAX] and flagging a reflection.
module vga_axis_step
  import vga_pkg::*;
#(
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  output logic [POS_W-1:0] nPos,
  output logic             nDir,
  output logic             hit
);

  localparam logic [POS_W:0]   MAX_E  = (POS_W+1)'(MAX);
  localparam logic [POS_W:0]   STEP_E = (POS_W+1)'(STEP);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

  logic [POS_W:0] posExt;
  logic [POS_W:0] sum;

  always_comb begin
    posExt = {1'b0, pos};
    sum    = posExt + STEP_E;
    nPos   = pos;
    nDir   = dir;
    hit    = 1'b0;
    if (dir) begin
      if (sum >= MAX_E) begin
        nPos = MAX_P;
        nDir = 1'b0;
        hit  = 1'b1;
      end else begin
        nPos = sum[POS_W-1:0];
      end
    end else begin
      // Landing exactly on 0 counts as a reflection.
      if (posExt <= STEP_E) begin
        nPos = '0;
        nDir = 1'b1;
        hit  = 1'b1;
      end else begin
        nPos = pos - STEP_P;
      end
    end
  end

endmodule

// File: rtl/vga_box_mover.sv
// Frame-synchronous box motion controller; commits new position during
// vertical blanking. Optional pause input enabled by VGA_BOX_PAUSE_EN.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic             dclk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             en,
`ifdef VGA_BOX_PAUSE_EN
  input  logic             pause,
`endif
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             dirX,
  output logic             dirY,
  output logic             upd,
  output logic             hit_x,
  output logic             hit_y
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [POS_W-1:0] X0_P = POS_W'(X0);
  localparam logic [POS_W-1:0] Y0_P = POS_W'(Y0);

  boxStateT state, stateNext;

  logic             vsD;
  logic             frameStart;
  logic             frameTake;
  logic [CNT_W-1:0] frameCnt;

  logic cntClr, cntInc, loadX, loadY, commit;

  logic [POS_W-1:0] shX, shY, nx, ny;
  logic             shDirX, shDirY, shHitX, shHitY;
  logic             ndx, ndy, hx, hy;

  assign frameStart = vsD & ~vs;
`ifdef VGA_BOX_PAUSE_EN
  assign frameTake = frameStart & ~pause;
`else
  assign frameTake = frameStart;
`endif

  vga_axis_step #(.MAX(H_ACTIVE - BOX_W), .STEP(STEP)) uStepX (
    .pos(pos_x), .dir(dirX), .nPos(nx), .nDir(ndx), .hit(hx)
  );

  vga_axis_step #(.MAX(V_ACTIVE - BOX_H), .STEP(STEP)) uStepY (
    .pos(pos_y), .dir(dirY), .nPos(ny), .nDir(ndy), .hit(hy)
  );

  always_ff @(posedge dclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    loadX     = 1'b0;
    loadY     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:   if (en) stateNext = WAIT;
      WAIT: begin
        // A counted frame keeps us in WAIT even if en just dropped.
        if (frameTake) begin
          if (frameCnt == CNT_LAST) begin
            cntClr    = 1'b1;
            stateNext = MOVE_X;
          end else begin
            cntInc = 1'b1;
          end
        end else if (!en) begin
          stateNext = IDLE;
        end
      end
      MOVE_X: begin
        loadX     = 1'b1;
        stateNext = MOVE_Y;
      end
      MOVE_Y: begin
        loadY     = 1'b1;
        stateNext = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        stateNext = en ? WAIT : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      vsD      <= 1'b1;
      frameCnt <= '0;
      pos_x    <= X0_P;
      pos_y    <= Y0_P;
      dirX     <= 1'b1;
      dirY     <= 1'b1;
      upd      <= 1'b0;
      hit_x    <= 1'b0;
      hit_y    <= 1'b0;
      shX      <= '0;
      shY      <= '0;
      shDirX   <= 1'b1;
      shDirY   <= 1'b1;
      shHitX   <= 1'b0;
      shHitY   <= 1'b0;
    end else begin
      vsD   <= vs;
      upd   <= commit;
      hit_x <= commit & shHitX;
      hit_y <= commit & shHitY;
      if (cntClr)      frameCnt <= '0;
      else if (cntInc) frameCnt <= frameCnt + CNT_W'(1);
      if (loadX) begin
        shX    <= nx;
        shDirX <= ndx;
        shHitX <= hx;
      end
      if (loadY) begin
        shY    <= ny;
        shDirY <= ndy;
        shHitY <= hy;
      end
      if (commit) begin
        pos_x <= shX;
        pos_y <= shY;
        dirX  <= shDirX;
        dirY  <= shDirY;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_mover.sv
// Randomized bench for vga_box_mover: three parameterisations share stimulus
// and are compared every cycle against a frame-level motion model.
module tb_vga_box_mover;
  import vga_pkg::*;

  logic dclk  = 1'b0;
  logic rst_n = 1'b0;
  logic vs    = 1'b1;
  logic en    = 1'b0;
  logic pause = 1'b0;

  always #5 dclk = ~dclk;

  logic [POS_W-1:0] pxD[3], pyD[3];
  logic dxD[3], dyD[3], updD[3], hxD[3], hyD[3];

  vga_box_mover u0 (
    .dclk(dclk), .rst_n(rst_n), .vs(vs), .en(en),
`ifdef VGA_BOX_PAUSE_EN
    .pause(pause),
`endif
    .pos_x(pxD[0]), .pos_y(pyD[0]), .dirX(dxD[0]), .dirY(dyD[0]),
    .upd(updD[0]), .hit_x(hxD[0]), .hit_y(hyD[0])
  );

  vga_box_mover #(.X0(606), .Y0(446)) u1 (
    .dclk(dclk), .rst_n(rst_n), .vs(vs), .en(en),
`ifdef VGA_BOX_PAUSE_EN
    .pause(pause),
`endif
    .pos_x(pxD[1]), .pos_y(pyD[1]), .dirX(dxD[1]), .dirY(dyD[1]),
    .upd(updD[1]), .hit_x(hxD[1]), .hit_y(hyD[1])
  );

  vga_box_mover #(.H_ACTIVE(64), .V_ACTIVE(48), .BOX_W(32), .BOX_H(16),
                  .STEP(3), .FRAME_DIV(3), .X0(1), .Y0(7)) u2 (
    .dclk(dclk), .rst_n(rst_n), .vs(vs), .en(en),
`ifdef VGA_BOX_PAUSE_EN
    .pause(pause),
`endif
    .pos_x(pxD[2]), .pos_y(pyD[2]), .dirX(dxD[2]), .dirY(dyD[2]),
    .upd(updD[2]), .hit_x(hxD[2]), .hit_y(hyD[2])
  );

  // Per-instance configuration mirrored from the overrides above.
  int mMaxX[3] = '{608, 608, 32};
  int mMaxY[3] = '{448, 448, 32};
  int mStep[3] = '{2, 2, 3};
  int mDiv[3]  = '{1, 1, 3};
  int mX0[3]   = '{0, 606, 1};
  int mY0[3]   = '{0, 446, 7};

  int mx[3], my[3], mCnt[3], lastUpd[3], pendCycle[3];
  bit mdx[3], mdy[3], pend[3];

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int updSeen = 0;
  bit monOn = 1'b0;

  always @(posedge dclk) cycleCnt++;

  task automatic checkVal(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycleCnt, got, exp);
    end
  endtask

  function automatic void stepAxis(input int p, input bit d, input int maxV, input int st,
                                   output int np, output bit nd, output bit h);
    h = 1'b0;
    nd = d;
    if (d) begin
      if (p + st >= maxV) begin np = maxV; nd = 1'b0; h = 1'b1; end
      else np = p + st;
    end else begin
      if (p <= st) begin np = 0; nd = 1'b1; h = 1'b1; end
      else np = p - st;
    end
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = mX0[i];  my[i] = mY0[i];
      mdx[i] = 1'b1;   mdy[i] = 1'b1;
      mCnt[i] = 0;     pend[i] = 1'b0;
      lastUpd[i] = -100;
    end
  endtask

  bit eu, ehx, ehy, ndx, ndy;
  int nx, ny;
  always @(negedge dclk) begin
    if (monOn) begin
      for (int i = 0; i < 3; i++) begin
        eu = 1'b0; ehx = 1'b0; ehy = 1'b0;
        if (pend[i] && cycleCnt == pendCycle[i]) begin
          stepAxis(mx[i], mdx[i], mMaxX[i], mStep[i], nx, ndx, ehx);
          stepAxis(my[i], mdy[i], mMaxY[i], mStep[i], ny, ndy, ehy);
          mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
          eu = 1'b1;
          pend[i] = 1'b0;
          updSeen++;
        end
        checkVal($sformatf("inst%0d", i),
                 {pxD[i], pyD[i], dxD[i], dyD[i], updD[i], hxD[i], hyD[i]},
                 {POS_W'(mx[i]), POS_W'(my[i]), mdx[i], mdy[i], eu, ehx, ehy});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge dclk);
      #1;
    end
  endtask

  // Drive a vs falling edge; a frame counts only when the controller is
  // enabled, not paused, and no earlier update is still in flight.
  task automatic vsFall();
    int t0;
    t0 = cycleCnt + 1;
    vs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (en && !pause && t0 >= lastUpd[i] + 4) begin
        mCnt[i]++;
        if (mCnt[i] == mDiv[i]) begin
          mCnt[i] = 0;
          pend[i] = 1'b1;
          pendCycle[i] = t0 + 3;
          lastUpd[i] = t0;
        end
      end
    end
  endtask

  initial begin
    int kind;
    modelReset();
    tick(3);
    monOn = 1'b1;
    rst_n = 1'b1;
    tick(1);
    en = 1'b1;
    tick(3);

    for (int it = 0; it < 700; it++) begin
      if (it >= 3) begin
        if (en ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0)) en = ~en;
`ifdef VGA_BOX_PAUSE_EN
        if ($urandom_range(0, 7) == 0) pause = ~pause;
`endif
      end
      tick(3);
      vsFall();
      kind = (it < 3) ? 3 : int'($urandom_range(0, 3));
      if (kind == 0) begin
        tick(1); vs = 1'b1;
        tick(1); vsFall();
      end else if (kind == 1) begin
        tick(1); en = 1'b0;
      end
      tick($urandom_range(1, 4));
      vs = 1'b1;
      tick(4);
    end

`ifdef VGA_BOX_PAUSE_EN
    en = 1'b1; pause = 1'b1;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      vsFall(); tick(2); vs = 1'b1; tick(5);
    end
    pause = 1'b0;
`endif

    // Reset while the update is in MOVE_X: no commit may follow.
    en = 1'b1; pause = 1'b0;
    tick(3);
    vsFall();
    tick(1);
    rst_n = 1'b0; vs = 1'b1;
    modelReset();
    tick(2);
    rst_n = 1'b1;
    tick(8);
    for (int k = 0; k < 3; k++) begin
      vsFall(); tick(2); vs = 1'b1; tick(6);
    end

    checks++;
    if (updSeen < 50) begin
      errors++;
      $display("FAIL updCount: got %0d expected at least 50", updSeen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
